mux_rr_reg: RTL and testbench

Parametrised successor to the team's registered single-bit mux. It selects one of NUM_CH multi-bit channels into a one-deep registered output stage, with valid/ready handshakes on every input and on the output. Two modes are supported: fixed select, driven by an external select, and round-robin auto-arbitration. The block sits between several producer streams and a single consumer.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_rr_reg_rr_arbiter.sv | 35 +++
 rtl/mux_rr_reg.sv | 105 ++++++++++
 tb/tb_mux_rr_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin / fixed-select channel mux.
// Holds the mode encodings, output-stage state type and payload slice helper.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Base bit offset of channel `index` inside the flattened payload bus.
    function automatic int unsigned ch_slice(input int unsigned index,
                                             input int unsigned data_width = 8);
        return index * data_width;
    endfunction

endpackage : mux_pkg

// File: rtl/mux_rr_reg_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester after the pointer wins.
// The pointer register lives in the parent so mode changes do not disturb it.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic [2**SEL_WIDTH-1:0] req_i,
    input  logic [SEL_WIDTH-1:0]    ptr_i,
    input  logic                    en_i,
    output logic [SEL_WIDTH-1:0]    gnt_idx_o,
    output logic                    gnt_vld_o
);

    localparam int unsigned NUM_CH = 2**SEL_WIDTH;

    logic [SEL_WIDTH-1:0] idx;

    // Offsets 1..NUM_CH wrap naturally in SEL_WIDTH bits; the pointer itself is last.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        if (en_i) begin
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                idx = ptr_i + SEL_WIDTH'(i);
                if (!gnt_vld_o && req_i[idx]) begin
                    gnt_idx_o = idx;
                    gnt_vld_o = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_rr_reg.sv
// Multi-channel mux into a one-deep registered output with valid/ready on all sides.
// Fixed-select or round-robin arbitration; full throughput when the consumer drains.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                mux_MODE,
    input  logic [SEL_WIDTH-1:0]                mux_SEL,
    input  logic [(2**SEL_WIDTH)*DATA_WIDTH-1:0] mux_IN,
    input  logic [2**SEL_WIDTH-1:0]             mux_VALID_IN,
    output logic [2**SEL_WIDTH-1:0]             mux_READY_IN,
    output logic [DATA_WIDTH-1:0]               mux_OUT,
    output logic [SEL_WIDTH-1:0]                mux_OUT_CH,
    output logic                                mux_OUT_VALID,
    input  logic                                mux_OUT_READY
);

    localparam int unsigned NUM_CH = 2**SEL_WIDTH;

    out_state_e            state_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [SEL_WIDTH-1:0]  ch_q;
    logic [SEL_WIDTH-1:0]  ptr_q;

    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [SEL_WIDTH-1:0]  rr_idx;
    logic                  rr_vld;
    logic [SEL_WIDTH-1:0]  gnt_idx;
    logic                  grant;
    logic                  accept;
    logic                  load;

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            ch_data[k] = mux_IN[ch_slice(k, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    rr_arbiter #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .req_i     (mux_VALID_IN),
        .ptr_i     (ptr_q),
        .en_i      (mux_MODE == MODE_RR),
        .gnt_idx_o (rr_idx),
        .gnt_vld_o (rr_vld)
    );

    always_comb begin
        if (mux_MODE == MODE_RR) begin
            gnt_idx = rr_idx;
            grant   = rr_vld;
        end else begin
            gnt_idx = mux_SEL;
            grant   = mux_VALID_IN[mux_SEL];
        end
    end

    assign accept = (state_q == ST_EMPTY) || mux_OUT_READY;
    // RST gates the handshake so nothing is offered upstream while reset is held.
    assign load   = RST && accept && grant;

    always_comb begin
        mux_READY_IN = '0;
        if (load) begin
            mux_READY_IN[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            ch_q    <= '0;
            ptr_q   <= SEL_WIDTH'(NUM_CH - 1);
        end else begin
            if (load) begin
                state_q <= ST_FULL;
                out_q   <= ch_data[gnt_idx];
                ch_q    <= gnt_idx;
                if (mux_MODE == MODE_RR) begin
                    ptr_q <= gnt_idx;
                end
            end else if (state_q == ST_FULL && mux_OUT_READY) begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign mux_OUT       = out_q;
    assign mux_OUT_CH    = ch_q;
    assign mux_OUT_VALID = (state_q == ST_FULL);

    a_ready_onehot0 : assert property (@(posedge CLK) disable iff (!RST)
        $onehot0(mux_READY_IN));

    a_hold_under_backpressure : assert property (@(posedge CLK) disable iff (!RST)
        (mux_OUT_VALID && !mux_OUT_READY) |=>
            (mux_OUT_VALID && $stable(mux_OUT) && $stable(mux_OUT_CH)));

endmodule : mux_rr_reg

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg: directed cases plus constrained-random traffic
// compared against a behavioural model of the output stage and arbitration rules.
module tb_mux_rr_reg;

    localparam int SW = 2;
    localparam int DW = 8;
    localparam int NC = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          mux_MODE;
    logic [SW-1:0] mux_SEL;
    logic [NC*DW-1:0] mux_IN;
    logic [NC-1:0] mux_VALID_IN;
    logic [NC-1:0] mux_READY_IN;
    logic [DW-1:0] mux_OUT;
    logic [SW-1:0] mux_OUT_CH;
    logic          mux_OUT_VALID;
    logic          mux_OUT_READY;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_valid, m_data, m_ch, m_ptr;
    int exp_rdy;
    int exp_g;

    mux_rr_reg #(
        .SEL_WIDTH  (SW),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .mux_MODE      (mux_MODE),
        .mux_SEL       (mux_SEL),
        .mux_IN        (mux_IN),
        .mux_VALID_IN  (mux_VALID_IN),
        .mux_READY_IN  (mux_READY_IN),
        .mux_OUT       (mux_OUT),
        .mux_OUT_CH    (mux_OUT_CH),
        .mux_OUT_VALID (mux_OUT_VALID),
        .mux_OUT_READY (mux_OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chan_data(input logic [NC*DW-1:0] bus, input int k);
        return int'((bus >> (k * DW)) & 32'hFF);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = NC - 1;
    endtask

    // Expected ready vector for the currently driven inputs.
    task automatic model_comb();
        int has;
        has   = 0;
        exp_g = 0;
        if (mux_MODE == 1'b0) begin
            exp_g = int'(mux_SEL);
            has   = int'(mux_VALID_IN[mux_SEL]);
        end else begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_ptr + k) % NC;
                if (!has && mux_VALID_IN[c]) begin
                    has   = 1;
                    exp_g = c;
                end
            end
        end
        exp_rdy = ((m_valid == 0 || mux_OUT_READY) && has) ? (1 << exp_g) : 0;
    endtask

    task automatic model_edge();
        if (exp_rdy != 0) begin
            m_valid = 1;
            m_data  = chan_data(mux_IN, exp_g);
            m_ch    = exp_g;
            if (mux_MODE == 1'b1) m_ptr = exp_g;
        end else if (m_valid == 1 && mux_OUT_READY) begin
            m_valid = 0;
        end
    endtask

    // One cycle: drive, check ready, clock, check registered outputs.
    task automatic step(input logic mode, input logic [SW-1:0] sel, input logic [NC-1:0] vld,
                        input logic [NC*DW-1:0] dat, input logic ordy);
        mux_MODE = mode; mux_SEL = sel; mux_VALID_IN = vld; mux_IN = dat; mux_OUT_READY = ordy;
        #1;
        model_comb();
        check("ready_in", 32'(mux_READY_IN), 32'(exp_rdy));
        @(posedge CLK);
        model_edge();
        #1;
        check("out_valid", 32'(mux_OUT_VALID), 32'(m_valid));
        check("out_data", 32'(mux_OUT), 32'(m_data));
        check("out_ch", 32'(mux_OUT_CH), 32'(m_ch));
    endtask

    task automatic do_reset();
        mux_MODE = 1'b0; mux_SEL = '0; mux_VALID_IN = '0; mux_IN = '0; mux_OUT_READY = 1'b0;
        #2 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
    endtask

    logic [NC-1:0]    pend_v;
    logic [NC*DW-1:0] pend_d;
    logic             r_mode;
    logic [SW-1:0]    r_sel;
    int exp_seq4 [5] = '{0, 1, 2, 3, 0};
    int exp_seq5 [4] = '{0, 3, 0, 3};

    initial begin
        RST = 1'b0;
        mux_MODE = 1'b0; mux_SEL = '0; mux_VALID_IN = '0; mux_IN = '0; mux_OUT_READY = 1'b0;
        model_reset();
        #1;
        check("reset_ready", 32'(mux_READY_IN), 32'h0);
        check("reset_valid", 32'(mux_OUT_VALID), 32'h0);
        do_reset();

        // Fixed mode load of ch2
        step(1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
        check("fixed_out", 32'(mux_OUT), 32'hA5);
        check("fixed_ch", 32'(mux_OUT_CH), 32'd2);
        check("fixed_valid", 32'(mux_OUT_VALID), 32'd1);

        // Asynchronous reset while FULL
        mux_MODE = 1'b1; mux_VALID_IN = 4'b1111; mux_IN = 32'h1122_3344; mux_OUT_READY = 1'b1;
        #2 RST = 1'b0;
        #1;
        check("arst_valid", 32'(mux_OUT_VALID), 32'h0);
        check("arst_out", 32'(mux_OUT), 32'h0);
        check("arst_ch", 32'(mux_OUT_CH), 32'h0);
        check("arst_ready", 32'(mux_READY_IN), 32'h0);
        do_reset();

        // Fixed-mode select mismatch drains the stage
        step(1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
        step(1'b0, 2'd1, 4'b0100, 32'h00A5_0000, 1'b1);
        check("mismatch_valid", 32'(mux_OUT_VALID), 32'h0);
        check("mismatch_keep", 32'(mux_OUT), 32'hA5);

        // Round-robin, all valid
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd0, 4'b1111, 32'hD3_C2_B1_A0, 1'b1);
            check("rr_all_ch", 32'(mux_OUT_CH), 32'(exp_seq4[i]));
            check("rr_all_valid", 32'(mux_OUT_VALID), 32'h1);
        end

        // Round-robin sparse with wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd0, 4'b1001, 32'hD3_C2_B1_A0, 1'b1);
            check("rr_sparse_ch", 32'(mux_OUT_CH), 32'(exp_seq5[i]));
        end

        // Backpressure
        do_reset();
        step(1'b0, 2'd0, 4'b0001, 32'h0000_003C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd1, 4'b0010, 32'h0000_7700, 1'b0);
            check("bp_hold", 32'(mux_OUT), 32'h3C);
        end
        mux_OUT_READY = 1'b1;
        #1;
        check("bp_release_ready", 32'(mux_READY_IN), 32'b0010);
        step(1'b0, 2'd1, 4'b0010, 32'h0000_7700, 1'b1);
        check("bp_release_out", 32'(mux_OUT), 32'h77);
        check("bp_release_valid", 32'(mux_OUT_VALID), 32'h1);

        // Random traffic honouring the upstream hold-until-accepted rule
        do_reset();
        pend_v = '0;
        pend_d = '0;
        r_mode = 1'b1;
        r_sel  = '0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) r_mode = 1'($urandom);
            if ($urandom_range(0, 3) == 0) r_sel  = SW'($urandom);
            for (int k = 0; k < NC; k++) begin
                if (!pend_v[k]) begin
                    pend_d[k*DW +: DW] = DW'($urandom);
                    pend_v[k] = ($urandom_range(0, 1) == 1);
                end
            end
            step(r_mode, r_sel, pend_v, pend_d, $urandom_range(0, 3) != 0);
            if (exp_rdy != 0) pend_v[exp_g] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux_rr_reg
